ldm_sequencer: RTL and testbench
================================

LDM_SEQUENCER -- requirements
Module: ldm_sequencer

Interface
REQ-001 SHALL have parameter LIST_W, default 16, meaning the register-list width (number of architectural registers addressable).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 SHALL have localparam IDX_W = $clog2(LIST_W), meaning the register-index width.
REQ-004 SHALL have port clk  in  1  the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  in  1  a block-transfer instruction is present in decode.
REQ-007 SHALL have port reglist  in  LIST_W  the register list; bit i selects register i.
REQ-008 SHALL have port base  in  ADDR_W  the base-register value.
REQ-009 SHALL have port mode  in  2  the addressing mode: IA=0, IB=1, DA=2, DB=3.
REQ-010 SHALL have port hold  in  1  a pipeline stall that freezes the sequence.
REQ-011 SHALL have port flush  in  1  aborts the sequence.
REQ-012 SHALL have port uop_valid  out  1  a micro-op is issued this cycle.
REQ-013 SHALL have port uop_reg  out  IDX_W  the register index of the issued micro-op.
REQ-014 SHALL have port uop_addr  out  ADDR_W  the memory address of the issued micro-op.
REQ-015 SHALL have port uop_last  out  1  the issued micro-op is the final one.
REQ-016 SHALL have port stall_f  out  1  stalls fetch/decode while the sequence is unfinished.
REQ-017 SHALL have port wb_valid  out  1  the base writeback value is valid.
REQ-018 SHALL have port wb_addr  out  ADDR_W  the base writeback value.

Function
REQ-019 SHALL implement an FSM with states IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-020 In IDLE, start=1 with a nonzero reglist and flush=0 SHALL latch the list, the popcount N and the start address, and go to RUN.
  - Start address: IA = base; IB = base+4; DA = base-4N+4; DB = base-4N.
REQ-021 In RUN with hold=0, each cycle SHALL assert uop_valid and drive uop_reg = the lowest set bit of the list.
  - The same cycle SHALL drive uop_addr = the current address.
  - The next edge SHALL clear that bit and add 4 to the address.
REQ-022 Registers SHALL always issue in ascending index order with ascending addresses, for every mode.
REQ-023 The first micro-op SHALL appear exactly 1 cycle after start is accepted.
  - N micro-ops SHALL occupy N consecutive non-held cycles.
REQ-024 uop_last SHALL equal 1 only together with the micro-op that has exactly one list bit remaining.
  - After that micro-op the FSM SHALL go to IDLE.
REQ-025 stall_f SHALL be 1 in the cycle start is accepted and in every RUN cycle except the uop_last cycle.
REQ-026 hold=1 in RUN SHALL freeze list, address and state; the same micro-op SHALL be re-presented with uop_valid=1.
REQ-027 flush=1 SHALL have priority over start and hold.
  - It SHALL force uop_valid=0 and stall_f=0 combinationally.
  - It SHALL return the FSM to IDLE at the next edge.
REQ-028 start while in RUN SHALL be ignored.
REQ-029 An empty reglist with start=1 SHALL go to DONE for exactly one cycle with uop_valid=0, stall_f=1 in the start cycle, and then return to IDLE.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_W, with wrap-around permitted and no error.

Reset
REQ-031 Asserting rst (low) SHALL, asynchronously and at any point mid-sequence, force state=IDLE and clear the latched list.
  - Every output SHALL reset to 0: uop_valid, uop_reg, uop_addr, uop_last, stall_f, wb_valid, wb_addr.
REQ-032 After deassertion, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-033 With macro LDM_WRITEBACK_EN defined, wb_valid SHALL pulse together with uop_last, and with the DONE cycle of an empty list.
  - wb_addr SHALL be base+4N for IA/IB and base-4N for DA/DB, with base latched at start.
REQ-034 With LDM_WRITEBACK_EN undefined, wb_valid and wb_addr SHALL be tied to 0 and no writeback adder SHALL be synthesised.

Structure
REQ-035 The shared package combi_pkg SHALL hold the ldm_mode_t enum (IA, IB, DA, DB) and the constant WORD_BYTES=4.
REQ-036 The lowest-set-bit finder SHALL be a sub-module lsb_pick, parametrised by LIST_W, with outputs for index and found.
REQ-037 The popcount SHALL be a function in combi_pkg.

Verification
REQ-038 IA: base=0x100, reglist=0x000B, start 1 cycle -> regs 0,1,3 at 0x100,0x104,0x108 on cycles 1-3; uop_last on cycle 3; wb_addr=0x10C.
REQ-039 DB: base=0x200, reglist=0x8001 -> reg 0 @0x1F8, reg 15 @0x1FC (uop_last); wb_addr=0x1F8; stall_f=1 on cycles 0-1 and 0 on cycle 2.
REQ-040 Hold: IB, base=0x0, reglist=0x0006, hold=1 on cycle 2 -> reg 1 @0x4 on cycle 1, reg 2 @0x8 on cycles 2 and 3 (cycle 2 held), uop_last on cycle 3.
REQ-041 Flush mid-op: reglist=0xFFFF, flush on cycle 4 -> uop_valid=0 and stall_f=0 on cycle 4, IDLE at cycle 5, wb_valid never asserted.
REQ-042 Empty list and wrap: reglist=0 -> no uop_valid, 1 DONE cycle; IA, base=0xFFFFFFFC, reglist=0x0003 -> addresses 0xFFFFFFFC, 0x00000000.
REQ-043 Async reset asserted mid-RUN between edges -> all outputs 0 immediately; after release, a new start is accepted on the first edge.

Source files
------------

// File: rtl/combi_pkg.sv
// ============================================================================
//  Module      : combi_pkg
//  Description : Shared types, constants and helpers for the block-transfer
//                (LDM/STM) micro-op sequencer.
//                  - ldm_mode_t  : addressing mode encoding (IA/IB/DA/DB)
//                  - ldm_state_t : sequencer FSM state encoding
//                  - WORD_BYTES  : bytes transferred per register
//                  - popcount()  : set-bit count of a register list
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package combi_pkg;

  localparam int WORD_BYTES = 4;

  // Widest register list popcount() accepts; narrower lists are zero-extended.
  localparam int POPCNT_MAX_W = 64;

  typedef enum logic [1:0] {
    LDM_IA = 2'd0,  // increment after
    LDM_IB = 2'd1,  // increment before
    LDM_DA = 2'd2,  // decrement after
    LDM_DB = 2'd3   // decrement before
  } ldm_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ldm_state_t;

  function automatic logic [6:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ldm_sequencer_lsb_pick.sv
// ============================================================================
//  Module      : lsb_pick
//  Description : Lowest-set-bit finder. Returns the index of the least
//                significant set bit of vec_i and whether any bit is set.
//  Ports       : vec_i   [LIST_W] input vector
//                idx_o   [IDX_W]  index of the lowest set bit (0 if none)
//                found_o [1]      vec_i has at least one bit set
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_pick #(
  parameter  int LIST_W = 16,
  localparam int IDX_W  = (LIST_W > 1) ? $clog2(LIST_W) : 1
) (
  input  logic [LIST_W-1:0] vec_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              found_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ldm_sequencer.sv
// ============================================================================
//  Module      : ldm_sequencer
//  Description : Breaks a block-transfer (load/store multiple) instruction
//                into one micro-op per selected register, issued in
//                ascending register order with ascending word addresses.
//  Ports       : clk        clock, all state on the rising edge
//                rst        asynchronous active-low reset
//                start      block-transfer instruction present in decode
//                reglist    register list, bit i selects register i
//                base       base-register value
//                mode       addressing mode IA=0, IB=1, DA=2, DB=3
//                hold       pipeline stall, freezes the sequence
//                flush      aborts the sequence (highest priority)
//                uop_valid  micro-op issued this cycle
//                uop_reg    register index of the micro-op
//                uop_addr   memory address of the micro-op
//                uop_last   micro-op is the final one
//                stall_f    stall fetch/decode while the sequence runs
//                wb_valid   base writeback value valid
//                wb_addr    base writeback value
//  Config      : LDM_WRITEBACK_EN - when defined, computes the base
//                writeback value; otherwise wb_valid/wb_addr are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldm_sequencer
  import combi_pkg::*;
#(
  parameter  int LIST_W = 16,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(LIST_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LIST_W-1:0] reglist,
  input  logic [ADDR_W-1:0] base,
  input  logic [1:0]        mode,
  input  logic              hold,
  input  logic              flush,
  output logic              uop_valid,
  output logic [IDX_W-1:0]  uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              stall_f,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ldm_state_t        state_q, state_d;
  logic [LIST_W-1:0] list_q,  list_d;   // registers still to be issued
  logic [ADDR_W-1:0] addr_q,  addr_d;   // address of the current micro-op
  logic [IDX_W-1:0]  reg_q;             // lowest set bit of list_q
  logic              last_q;            // list_q has exactly one bit set

  // --------------------------------------------------------------------------
  // Start-address computation
  // --------------------------------------------------------------------------
  ldm_mode_t         mode_w;
  logic [6:0]        cnt_w;
  logic [ADDR_W-1:0] word_w;
  logic [ADDR_W-1:0] span_w;
  logic [ADDR_W-1:0] start_addr_w;
  logic              accept_w;

  assign mode_w   = ldm_mode_t'(mode);
  assign cnt_w    = popcount(POPCNT_MAX_W'(reglist));
  assign word_w   = ADDR_W'(WORD_BYTES);
  assign span_w   = ADDR_W'(cnt_w) * word_w;
  assign accept_w = (state_q == ST_IDLE) && start && !flush;

  // Decrementing modes still transfer upward: the lowest register sits at
  // the bottom of the block, so only the starting point differs per mode.
  always_comb begin
    start_addr_w = base;
    case (mode_w)
      LDM_IA:  start_addr_w = base;
      LDM_IB:  start_addr_w = base + word_w;
      LDM_DA:  start_addr_w = base - span_w + word_w;
      LDM_DB:  start_addr_w = base - span_w;
      default: start_addr_w = base;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [LIST_W-1:0] list_clr_w;

  // x & (x-1) clears the lowest set bit, i.e. retires the micro-op issued now.
  assign list_clr_w = list_q & (list_q - LIST_W'(1));

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    if (flush) begin
      state_d = ST_IDLE;
      list_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            if (|reglist) begin
              state_d = ST_RUN;
              list_d  = reglist;
              addr_d  = start_addr_w;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (!hold) begin
            list_d  = list_clr_w;
            addr_d  = addr_q + word_w;
            state_d = (|list_clr_w) ? ST_RUN : ST_IDLE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The index and last flag are looked ahead from list_d so that they are
  // registered alongside the list they describe.
  logic [IDX_W-1:0] nxt_idx_w;
  logic             nxt_found_w;
  logic             last_d;

  lsb_pick #(
    .LIST_W (LIST_W)
  ) u_lsb_pick (
    .vec_i   (list_d),
    .idx_o   (nxt_idx_w),
    .found_o (nxt_found_w)
  );

  assign last_d = nxt_found_w && !(|(list_d & (list_d - LIST_W'(1))));

`ifdef LDM_WRITEBACK_EN
  logic [ADDR_W-1:0] wb_q;
  logic [ADDR_W-1:0] wb_d;

  assign wb_d = ((mode_w == LDM_IA) || (mode_w == LDM_IB)) ? (base + span_w)
                                                           : (base - span_w);
`endif

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      last_q  <= 1'b0;
`ifdef LDM_WRITEBACK_EN
      wb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      reg_q   <= nxt_idx_w;
      last_q  <= last_d;
`ifdef LDM_WRITEBACK_EN
      // Base is captured at acceptance; later changes to base are ignored.
      if (accept_w) begin
        wb_q <= wb_d;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic run_w;

  assign run_w     = (state_q == ST_RUN);
  assign uop_valid = run_w && !flush;
  assign uop_reg   = reg_q;
  assign uop_addr  = addr_q;
  assign uop_last  = uop_valid && last_q;

  // Decode must stop in the acceptance cycle already, before RUN is entered.
  // Gating with rst keeps stall_f low while reset is held with start high.
  assign stall_f = rst && !flush &&
                   (((state_q == ST_IDLE) && start) || (run_w && !last_q));

`ifdef LDM_WRITEBACK_EN
  assign wb_valid = uop_last || ((state_q == ST_DONE) && !flush);
  assign wb_addr  = wb_q;
`else
  assign wb_valid = 1'b0;
  assign wb_addr  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ldm_sequencer.sv
// ============================================================================
//  Module      : tb_ldm_sequencer
//  Description : Self-checking bench for ldm_sequencer. Stimulus pushes the
//                expected per-cycle response into a queue; a monitor pops
//                and compares on every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ldm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] reglist = '0;
  logic [31:0] base = '0;
  logic [1:0]  mode = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        uop_valid;
  logic [3:0]  uop_reg;
  logic [31:0] uop_addr;
  logic        uop_last;
  logic        stall_f;
  logic        wb_valid;
  logic [31:0] wb_addr;

`ifdef LDM_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  always #5 clk = ~clk;

  ldm_sequencer #(
    .LIST_W (16),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reglist   (reglist),
    .base      (base),
    .mode      (mode),
    .hold      (hold),
    .flush     (flush),
    .uop_valid (uop_valid),
    .uop_reg   (uop_reg),
    .uop_addr  (uop_addr),
    .uop_last  (uop_last),
    .stall_f   (stall_f),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr)
  );

  typedef struct {
    logic        v;
    logic [3:0]  r;
    logic [31:0] a;
    logic        l;
    logic        s;
    logic        wv;
    logic [31:0] wa;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("uop_valid", uop_valid, e.v);
          check("uop_last",  uop_last,  e.l);
          check("stall_f",   stall_f,   e.s);
          if (e.v) begin
            check("uop_reg",  uop_reg,  e.r);
            check("uop_addr", uop_addr, e.a);
          end
          check("wb_valid", wb_valid, e.wv);
`ifdef LDM_WRITEBACK_EN
          if (e.wv) check("wb_addr", wb_addr, e.wa);
`else
          check("wb_addr_tied", wb_addr, 32'h0);
`endif
        end else if (uop_valid) begin
          check("unexpected_uop", uop_valid, 1'b0);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic push(input logic v, input logic [3:0] r, input logic [31:0] a,
                      input logic l, input logic s, input logic wv, input logic [31:0] wa);
    exp_t e;
    e.v = v; e.r = r; e.a = a; e.l = l; e.s = s; e.wv = wv; e.wa = wa;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, uop_valid, 1'b0);
    check({tag, "_reg"},   uop_reg,   4'h0);
    check({tag, "_addr"},  uop_addr,  32'h0);
    check({tag, "_last"},  uop_last,  1'b0);
    check({tag, "_stall"}, stall_f,   1'b0);
    check({tag, "_wbv"},   wb_valid,  1'b0);
    check({tag, "_wba"},   wb_addr,   32'h0);
  endtask

  // One block transfer. Reference model: the selected registers in ascending
  // order, the k-th at start_address + 4k, computed from the mode table.
  task automatic do_seq(input logic [15:0] lst, input logic [31:0] b, input logic [1:0] md,
                        input int flush_cyc, input int hold_cyc, input bit rnd);
    int          regs[$];
    logic [31:0] addrs[$];
    int          n;
    int          k;
    int          c;
    logic [31:0] sa;
    logic [31:0] wa;
    bit          h;
    bit          f;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        regs.push_back(i);
        n++;
      end
    end
    case (md)
      2'd0:    sa = b;
      2'd1:    sa = b + 32'd4;
      2'd2:    sa = b - 32'(4 * n) + 32'd4;
      default: sa = b - 32'(4 * n);
    endcase
    wa = (md < 2'd2) ? (b + 32'(4 * n)) : (b - 32'(4 * n));
    for (int i = 0; i < n; i++) addrs.push_back(sa + 32'(4 * i));

    // Acceptance cycle
    start = 1'b1; reglist = lst; base = b; mode = md; hold = 1'b0;
    f = (flush_cyc == 0);
    flush = f;
    if (f) begin
      push(0, 0, 0, 0, 0, 0, 0);
      tick();
      start = 1'b0; flush = 1'b0;
      push(0, 0, 0, 0, 0, 0, 0);
      tick();
      return;
    end
    push(0, 0, 0, 0, 1, 0, 0);
    tick();
    start = 1'b0;
    base = $urandom; reglist = 16'($urandom); mode = 2'($urandom);

    if (n == 0) begin
      push(0, 0, 0, 0, 0, WB, b);
      tick();
      return;
    end

    k = 0;
    c = 1;
    while (k < n) begin
      f = (c == flush_cyc);
      h = (c == hold_cyc) || (rnd && ($urandom_range(0, 3) == 0));
      hold = h; flush = f;
      start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      reglist = 16'($urandom);
      if (f) begin
        push(0, 0, 0, 0, 0, 0, 0);
        tick();
        flush = 1'b0; hold = 1'b0; start = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0);
        tick();
        return;
      end
      push(1, 4'(regs[k]), addrs[k], k == n - 1, k != n - 1, WB && (k == n - 1), wa);
      tick();
      if (!h) k++;
      c++;
    end
    hold = 1'b0; start = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int guard;
    rst = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #3;
    rst = 1'b1;

    do_seq(16'h000B, 32'h0000_0100, 2'd0, -1, -1, 1'b0);  // IA
    do_seq(16'h8001, 32'h0000_0200, 2'd3, -1, -1, 1'b0);  // DB
    do_seq(16'h0006, 32'h0000_0000, 2'd1, -1,  2, 1'b0);  // IB with hold
    do_seq(16'hFFFF, 32'h0000_1000, 2'd0,  4, -1, 1'b0);  // flush mid-op
    do_seq(16'h0000, 32'h0000_0300, 2'd2, -1, -1, 1'b0);  // empty list
    do_seq(16'h0003, 32'hFFFF_FFFC, 2'd0, -1, -1, 1'b0);  // wrap
    do_seq(16'h0024, 32'h0000_0400, 2'd2, -1, -1, 1'b0);  // DA
    do_seq(16'h0001, 32'h0000_0500, 2'd1,  0, -1, 1'b0);  // flush beats start

    // Asynchronous reset mid-RUN, between edges
    start = 1'b1; reglist = 16'hFFFF; base = 32'h40; mode = 2'd0;
    push(0, 0, 0, 0, 1, 0, 0);
    tick();
    start = 1'b0;
    push(1, 4'd0, 32'h40, 0, 1, 0, 0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    do_seq(16'h0005, 32'h0000_0800, 2'd0, -1, -1, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 60; t++) begin
      logic [15:0] lst;
      int          fc;
      lst = 16'($urandom);
      if ($urandom_range(0, 2) == 0) lst = lst & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) lst = 16'h0000;
      fc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_seq(lst, $urandom, 2'($urandom), fc, -1, 1'b1);
    end

    start = 1'b0; hold = 1'b0; flush = 1'b0;
    guard = 0;
    while ((exp_q.size() > 0) && (guard < 10)) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
